add_issue_collect: RTL and testbench

//  Issue/collect stage wrapped around the 2-cycle pipelined 8-bit adder (module A, instantiated by the parent).

---
 rtl/add_issue_collect.sv | 120 ++++++++++++
 tb/tb_add_issue_collect.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/add_issue_collect.sv
// Issue/collect stage around an external LATENCY-cycle pipelined adder.
// Operand FIFO feeds the adder; a credit counter keeps the result FIFO from overflowing.
module add_issue_collect #(
    parameter int unsigned W         = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   in_a,
    input  logic [W-1:0]                   in_b,
    output logic [W-1:0]                   add_a,
    output logic [W-1:0]                   add_b,
    input  logic [W-1:0]                   add_out,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [W-1:0]                   res_data,
    output logic [$clog2(RES_DEPTH+1)-1:0] inflight
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned OCW = $clog2(DEPTH + 1);
    localparam int unsigned RW  = $clog2(RES_DEPTH);
    localparam int unsigned CW  = $clog2(RES_DEPTH + 1);

    logic [W-1:0]       op_a_q [DEPTH];
    logic [W-1:0]       op_b_q [DEPTH];
    logic [AW-1:0]      op_wr_q, op_wr_d;
    logic [AW-1:0]      op_rd_q, op_rd_d;
    logic [OCW-1:0]     op_cnt_q, op_cnt_d;

    logic [LATENCY-1:0] vp_q, vp_d;

    logic [W-1:0]       res_mem_q [RES_DEPTH];
    logic [RW-1:0]      res_wr_q, res_wr_d;
    logic [RW-1:0]      res_rd_q, res_rd_d;
    logic [CW-1:0]      res_cnt_q, res_cnt_d;
    logic [CW-1:0]      credit_q, credit_d;

    logic push, issue, res_push, res_pop;

    always_comb begin
        // in_ready looks only at the registered count, so a full FIFO never passes through.
        in_ready  = (op_cnt_q != OCW'(DEPTH));
        push      = in_valid && in_ready;
        issue     = (op_cnt_q != '0) && (credit_q < CW'(RES_DEPTH));
        add_a     = issue ? op_a_q[op_rd_q] : '0;
        add_b     = issue ? op_b_q[op_rd_q] : '0;

        res_valid = (res_cnt_q != '0);
        res_data  = res_valid ? res_mem_q[res_rd_q] : '0;
        res_push  = vp_q[LATENCY-1];
        res_pop   = res_valid && res_ready;
        inflight  = credit_q;

        op_wr_d   = push ? op_wr_q + AW'(1) : op_wr_q;
        op_rd_d   = issue ? op_rd_q + AW'(1) : op_rd_q;
        op_cnt_d  = op_cnt_q;
        case ({push, issue})
            2'b10:   op_cnt_d = op_cnt_q + OCW'(1);
            2'b01:   op_cnt_d = op_cnt_q - OCW'(1);
            default: op_cnt_d = op_cnt_q;
        endcase

        vp_d      = (vp_q << 1) | LATENCY'(issue);

        res_wr_d  = res_push ? res_wr_q + RW'(1) : res_wr_q;
        res_rd_d  = res_pop ? res_rd_q + RW'(1) : res_rd_q;
        res_cnt_d = res_cnt_q;
        case ({res_push, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + CW'(1);
            2'b01:   res_cnt_d = res_cnt_q - CW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase

        // A credit is held from issue until the consumer pops the result.
        credit_d  = credit_q;
        case ({issue, res_pop})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_a_q[op_wr_q] <= in_a;
            op_b_q[op_wr_q] <= in_b;
        end
        if (res_push) begin
            res_mem_q[res_wr_q] <= add_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q   <= '0;
            op_rd_q   <= '0;
            op_cnt_q  <= '0;
            vp_q      <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            credit_q  <= '0;
        end else begin
            op_wr_q   <= op_wr_d;
            op_rd_q   <= op_rd_d;
            op_cnt_q  <= op_cnt_d;
            vp_q      <= vp_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
            credit_q  <= credit_d;
        end
    end

endmodule

// File: tb/tb_add_issue_collect.sv
// Randomized and directed bench for add_issue_collect with a 2-cycle adder model
// and a queue-based cycle-level reference model.
module tb_add_issue_collect;

    localparam int unsigned W         = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned RES_DEPTH = 4;
    localparam int unsigned LATENCY   = 2;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           in_valid;
    logic                           in_ready;
    logic [W-1:0]                   in_a, in_b;
    logic [W-1:0]                   add_a, add_b, add_out;
    logic                           res_valid;
    logic                           res_ready;
    logic [W-1:0]                   res_data;
    logic [$clog2(RES_DEPTH+1)-1:0] inflight;

    always #5 clk = ~clk;

    add_issue_collect #(.W(W), .DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .inflight(inflight)
    );

    // Two-stage pipelined adder, flushed by the shared reset.
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= add_a + add_b;
            s2_q <= s1_q;
        end
    end
    assign add_out = s2_q;

    typedef struct {
        int unsigned sum;
        int unsigned due;
    } pend_t;

    int unsigned opq_a[$], opq_b[$];
    pend_t       pend[$];
    int unsigned resq[$];
    int unsigned snd_a[$], snd_b[$];
    int unsigned credits, cyc;
    int unsigned pushes, pops;
    int unsigned last_obs;
    int          push_cyc, first_val_cyc;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send(input int unsigned a, input int unsigned b);
        snd_a.push_back(a);
        snd_b.push_back(b);
    endtask

    task automatic model_clear();
        opq_a.delete(); opq_b.delete(); pend.delete(); resq.delete();
        snd_a.delete(); snd_b.delete();
        credits = 0;
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
    task automatic cycle();
        bit          e_rdy, e_iss, e_val;
        int unsigned e_a, e_b, e_d;
        pend_t       p;
        in_valid = (snd_a.size() != 0);
        in_a     = in_valid ? W'(snd_a[0]) : '0;
        in_b     = in_valid ? W'(snd_b[0]) : '0;
        @(negedge clk);
        e_rdy = (opq_a.size() != DEPTH);
        e_iss = (opq_a.size() != 0) && (credits < RES_DEPTH);
        e_a   = e_iss ? opq_a[0] : 0;
        e_b   = e_iss ? opq_b[0] : 0;
        e_val = (resq.size() != 0);
        e_d   = e_val ? resq[0] : 0;
        if (!rst) begin
            chk("in_ready", in_ready, e_rdy);
            chk("add_a", add_a, e_a);
            chk("add_b", add_b, e_b);
            chk("res_valid", res_valid, e_val);
            chk("res_data", res_data, e_d);
            chk("inflight", inflight, credits);
            chk("credit_bound", (inflight <= RES_DEPTH), 1);
            if (res_valid && first_val_cyc < 0) first_val_cyc = int'(cyc);
            if (res_valid && res_ready) last_obs = res_data;
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (res_ready && e_val) begin
                void'(resq.pop_front());
                credits--;
                pops++;
            end
            if (e_iss) begin
                p.sum = (opq_a[0] + opq_b[0]) % 256;
                p.due = cyc + LATENCY + 1;
                pend.push_back(p);
                void'(opq_a.pop_front());
                void'(opq_b.pop_front());
                credits++;
            end
            if (in_valid && e_rdy) begin
                opq_a.push_back(snd_a.pop_front());
                opq_b.push_back(snd_b.pop_front());
                pushes++;
                push_cyc = int'(cyc);
            end
            while (pend.size() != 0 && pend[0].due == cyc + 1) begin
                p = pend.pop_front();
                resq.push_back(p.sum);
            end
        end
        cyc++;
        #1;
    endtask

    int unsigned p0, q0;

    initial begin
        cyc = 0; pushes = 0; pops = 0; last_obs = 0;
        push_cyc = -1; first_val_cyc = -1;
        model_clear();
        rst = 1'b1; res_ready = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_inflight", inflight, 0);

        // Single pair, minimum latency
        res_ready = 1'b1;
        first_val_cyc = -1;
        send(3, 4);
        repeat (8) cycle();
        chk("t1_sum", last_obs, 7);
        chk("t1_latency", first_val_cyc - push_cyc, LATENCY + 2);

        // Back-to-back
        q0 = pops;
        send(1, 1); send(2, 2); send(3, 3); send(4, 4);
        repeat (10) cycle();
        chk("t2_pops", pops - q0, 4);
        chk("t2_last", last_obs, 8);

        // Wraparound
        send(200, 100);
        repeat (8) cycle();
        chk("t3_wrap", last_obs, 44);

        // Stalled consumer
        res_ready = 1'b0;
        p0 = pushes; q0 = pops;
        for (int i = 0; i < 10; i++) send(10 + i, 2 * i);
        repeat (15) cycle();
        chk("t4_accepted", pushes - p0, 8);
        chk("t4_inflight", inflight, 4);
        chk("t4_in_ready", in_ready, 0);
        res_ready = 1'b1;
        repeat (20) cycle();
        chk("t4_delivered", pops - q0, 10);
        chk("t4_last", last_obs, (19 + 18) % 256);

        // Random traffic with periodic long stalls
        for (int i = 0; i < 10000; i++) begin
            if (snd_a.size() == 0 && ($urandom % 4) != 0)
                send($urandom_range(0, 255), $urandom_range(0, 255));
            res_ready = (((i / 200) % 4) == 3) ? 1'b0 : (($urandom % 4) != 0);
            cycle();
        end
        res_ready = 1'b1;
        repeat (30) cycle();
        chk("t5_drained", inflight, 0);

        // Reset with work queued and in flight
        res_ready = 1'b0;
        q0 = pops;
        for (int i = 0; i < 7; i++) send(50 + i, 7);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_res_valid", res_valid, 0);
        chk("t6_inflight", inflight, 0);
        chk("t6_in_ready", in_ready, 1);
        res_ready = 1'b1;
        repeat (20) cycle();
        chk("t6_no_stale", pops - q0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
